// File: rtl/sccb_arbiter.sv
// sccb_arbiter
//   Shares one SCCB master between two requesters: requester 0 is the camera
//   init sequencer, requester 1 does runtime register access. One register
//   transaction is in flight at a time. Each transaction follows this
//   sequence:
//     1. A round-robin accept.
//     2. A start/hold handshake with the master until its end pulse.
//     3. A completion pulse back to the owner.
//     4. A forced bus-free gap before the next accept.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        asynchronous, active-low reset
//   req_valid    per-requester request strobe (bit i = requester i)
//   req_rd       per-requester read(1)/write(0) select
//   req_subaddr  requester i subaddress in [8i+7:8i]
//   req_wdata    requester i write data in [8i+7:8i]
//   req_ready    one-cycle accept pulse (one-hot or zero)
//   req_done     one-cycle completion pulse to the owner
//   req_err      one-cycle error pulse, coincident with req_done
//   rdata        read data, valid on the req_done cycle, held until next done
//   busy         high from accept until the gap expires
//   m_start      start to the SCCB master, held until m_end
//   m_rd         read/write select to the master
//   m_subaddr    subaddress to the master
//   m_wdata      write data to the master
//   m_end        one-cycle transaction-complete pulse from the master
//   m_rdata      master read data, valid with m_end
//
// Optional feature
//   SCCB_TIMEOUT_EN: when defined, a 16-bit watchdog aborts a transaction
//   that sees no m_end within TIMEOUT_CYCLES cycles. An aborted transaction
//   completes with req_err and rdata = 8'hFF. When not defined, req_err is
//   tied low and the arbiter waits for m_end indefinitely.

module sccb_arbiter #(
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_rd,
  input  logic [15:0] req_subaddr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        m_start,
  output logic        m_rd,
  output logic [7:0]  m_subaddr,
  output logic [7:0]  m_wdata,
  input  logic        m_end,
  input  logic [7:0]  m_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  // A gap of zero would let a new grant collide with the done cycle, so the
  // load value is clamped to at least one.
  localparam logic [15:0] GapLoad = 16'((GAP_CYCLES < 1) ? 1 : GAP_CYCLES);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [15:0] gap_cnt;
  logic        winner;

`ifdef SCCB_TIMEOUT_EN
  localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog;
`endif

  // Round-robin pick: on a tie the requester that did not win last time
  // gets the bus; a lone valid requester wins outright.
  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) begin
      winner = ~last_grant;
    end
  end

  // Main transaction FSM. The ready/done/err pulses default low every cycle,
  // so each one lasts exactly one cycle. The master-side fields are latched
  // at accept and stay put until the next accept, which keeps them stable
  // for the whole issue/wait/done window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= 16'd0;
      req_ready  <= 2'b00;
      req_done   <= 2'b00;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      m_start    <= 1'b0;
      m_rd       <= 1'b0;
      m_subaddr  <= 8'h00;
      m_wdata    <= 8'h00;
`ifdef SCCB_TIMEOUT_EN
      req_err    <= 2'b00;
      wdog       <= 16'd0;
`endif
    end else begin
      req_ready <= 2'b00;
      req_done  <= 2'b00;
`ifdef SCCB_TIMEOUT_EN
      req_err   <= 2'b00;
`endif
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready <= winner ? 2'b10 : 2'b01;
            owner     <= winner;
            m_rd      <= winner ? req_rd[1] : req_rd[0];
            m_subaddr <= winner ? req_subaddr[15:8] : req_subaddr[7:0];
            m_wdata   <= winner ? req_wdata[15:8] : req_wdata[7:0];
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_start <= 1'b1;
          state   <= S_WAIT;
`ifdef SCCB_TIMEOUT_EN
          wdog    <= 16'd0;
`endif
        end
        S_WAIT: begin
          if (m_end) begin
            if (m_rd) begin
              rdata <= m_rdata;
            end
            m_start  <= 1'b0;
            req_done <= owner ? 2'b10 : 2'b01;
            state    <= S_DONE;
          end
`ifdef SCCB_TIMEOUT_EN
          else if (wdog == WdogLast) begin
            m_start  <= 1'b0;
            rdata    <= 8'hFF;
            req_done <= owner ? 2'b10 : 2'b01;
            req_err  <= owner ? 2'b10 : 2'b01;
            state    <= S_DONE;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end
        S_DONE: begin
          last_grant <= owner;
          gap_cnt    <= GapLoad;
          state      <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt <= 16'd1) begin
            gap_cnt <= 16'd0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef SCCB_TIMEOUT_EN
  assign req_err = 2'b00;
`endif

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter
//   Directed bench for sccb_arbiter. It acts as both requesters and the SCCB
//   master, and compares every observed output against hand-derived values.
//   The timeout scenario is only compiled when SCCB_TIMEOUT_EN is defined.

module tb_sccb_arbiter;

  localparam int Gap     = 8;
  localparam int Timeout = 100;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_rd;
  logic [15:0] req_subaddr;
  logic [15:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [7:0]  rdata;
  logic        busy;
  logic        m_start;
  logic        m_rd;
  logic [7:0]  m_subaddr;
  logic [7:0]  m_wdata;
  logic        m_end;
  logic [7:0]  m_rdata;

  int checkCount = 0;
  int passCount  = 0;
  int cycle      = 0;
  int lastDone   = 0;

  sccb_arbiter #(
    .GAP_CYCLES    (Gap),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_subaddr(req_subaddr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .req_err    (req_err),
    .rdata      (rdata),
    .busy       (busy),
    .m_start    (m_start),
    .m_rd       (m_rd),
    .m_subaddr  (m_subaddr),
    .m_wdata    (m_wdata),
    .m_end      (m_end),
    .m_rdata    (m_rdata)
  );

  // Free-running clock and an edge counter used for latency measurements.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Hard stop in case something wedges the stimulus.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "[TB] stopped");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rd,
                               input logic [15:0] subaddr, input logic [15:0] wdata);
    req_valid   = valid;
    req_rd      = rd;
    req_subaddr = subaddr;
    req_wdata   = wdata;
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Waits for an accept, checks the grant and the master-side fields, then
  // plays the master and finishes with an m_end pulse carrying mrdata.
  task automatic serveOne(input logic [1:0] expGrant, input logic expRd,
                          input logic [7:0] expSa, input logic [7:0] expWd,
                          input logic [7:0] mrdata, input logic [7:0] expRdata,
                          input logic [1:0] validAfter, input bit checkGap);
    int n;
    int acceptCycle;
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin
      step();
      n++;
    end
    checkOutput("grant", req_ready, expGrant);
    acceptCycle = cycle;
    if (checkGap) begin
      checkOutput("gap_after_done", 16'(acceptCycle - lastDone >= Gap + 1), 16'd1);
    end
    req_valid = validAfter;
    step();
    checkOutput("m_start_after_accept", m_start, 1'b1);
    checkOutput("ready_one_cycle", req_ready, 2'b00);
    checkOutput("m_rd", m_rd, expRd);
    checkOutput("m_subaddr", m_subaddr, expSa);
    checkOutput("m_wdata", m_wdata, expWd);
    step();
    step();
    checkOutput("m_start_held", m_start, 1'b1);
    m_end   = 1'b1;
    m_rdata = mrdata;
    step();
    m_end = 1'b0;
    checkOutput("done", req_done, expGrant);
    checkOutput("err_clear", req_err, 2'b00);
    checkOutput("rdata", rdata, expRdata);
    checkOutput("m_start_drop", m_start, 1'b0);
    lastDone = cycle;
  endtask

  initial begin
    int n;
    int acc;
    reset   = 1'b0;
    m_end   = 1'b0;
    m_rdata = 8'h00;
    applyStimulus(2'b00, 2'b00, 16'h0000, 16'h0000);
    step();
    step();

    // Reset values.
    checkOutput("rst_ready", req_ready, 2'b00);
    checkOutput("rst_done", req_done, 2'b00);
    checkOutput("rst_err", req_err, 2'b00);
    checkOutput("rst_rdata", rdata, 8'h00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_m_start", m_start, 1'b0);
    checkOutput("rst_m_rd", m_rd, 1'b0);
    checkOutput("rst_m_subaddr", m_subaddr, 8'h00);
    checkOutput("rst_m_wdata", m_wdata, 8'h00);
    reset = 1'b1;

    // Single write from requester 0, then measure when busy falls.
    $display("[TB] single write from requester 0");
    applyStimulus(2'b01, 2'b00, 16'h0012, 16'h0080);
    serveOne(2'b01, 1'b0, 8'h12, 8'h80, 8'h55, 8'h00, 2'b00, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    checkOutput("busy_fall_edges", 16'(n), 16'(Gap + 1));

    // Both requesters always valid after a fresh reset: 0,1,0,1.
    $display("[TB] round robin with both valid");
    resetDut();
    applyStimulus(2'b11, 2'b00, 16'h2120, 16'hB1B0);
    serveOne(2'b01, 1'b0, 8'h20, 8'hB0, 8'h00, 8'h00, 2'b11, 1'b0);
    serveOne(2'b10, 1'b0, 8'h21, 8'hB1, 8'h00, 8'h00, 2'b11, 1'b1);
    serveOne(2'b01, 1'b0, 8'h20, 8'hB0, 8'h00, 8'h00, 2'b11, 1'b1);
    serveOne(2'b10, 1'b0, 8'h21, 8'hB1, 8'h00, 8'h00, 2'b00, 1'b1);

    // Read from requester 1, then writes must leave rdata alone.
    $display("[TB] read data capture and hold");
    applyStimulus(2'b10, 2'b10, 16'h0A00, 16'h0000);
    serveOne(2'b10, 1'b1, 8'h0A, 8'h00, 8'h76, 8'h76, 2'b00, 1'b1);
    applyStimulus(2'b01, 2'b00, 16'h0033, 16'h0044);
    serveOne(2'b01, 1'b0, 8'h33, 8'h44, 8'h99, 8'h76, 2'b00, 1'b1);
    applyStimulus(2'b10, 2'b00, 16'h3400, 16'h4500);
    serveOne(2'b10, 1'b0, 8'h34, 8'h45, 8'hAB, 8'h76, 2'b00, 1'b1);

    // Stray m_end while idle.
    $display("[TB] m_end while idle");
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    checkOutput("idle_before_stray", busy, 1'b0);
    step();
    m_end   = 1'b1;
    m_rdata = 8'hEE;
    step();
    m_end = 1'b0;
    checkOutput("stray_done", req_done, 2'b00);
    checkOutput("stray_busy", busy, 1'b0);
    checkOutput("stray_ready", req_ready, 2'b00);
    checkOutput("stray_rdata", rdata, 8'h76);
    step();
    checkOutput("stray_done_late", req_done, 2'b00);
    checkOutput("stray_m_start", m_start, 1'b0);

    // Reset in the middle of the wait phase.
    $display("[TB] reset during wait");
    applyStimulus(2'b01, 2'b00, 16'h005A, 16'h0011);
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin
      step();
      n++;
    end
    checkOutput("mid_grant", req_ready, 2'b01);
    req_valid = 2'b00;
    step();
    checkOutput("mid_m_start", m_start, 1'b1);
    step();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_m_start", m_start, 1'b0);
    checkOutput("async_busy", busy, 1'b0);
    checkOutput("async_subaddr", m_subaddr, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    checkOutput("abandon_done", req_done, 2'b00);
    step();
    checkOutput("abandon_done2", req_done, 2'b00);
    applyStimulus(2'b10, 2'b00, 16'h6600, 16'h7700);
    serveOne(2'b10, 1'b0, 8'h66, 8'h77, 8'h00, 8'h00, 2'b00, 1'b0);

`ifdef SCCB_TIMEOUT_EN
    // Master never answers: watchdog abort, then a late m_end is ignored.
    $display("[TB] watchdog abort");
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    applyStimulus(2'b01, 2'b00, 16'h0040, 16'h0041);
    n = 0;
    while (req_ready == 2'b00 && n < 100) begin
      step();
      n++;
    end
    checkOutput("to_grant", req_ready, 2'b01);
    acc = cycle;
    req_valid = 2'b00;
    n = 0;
    while (req_done == 2'b00 && n < 300) begin
      step();
      n++;
    end
    checkOutput("to_done", req_done, 2'b01);
    checkOutput("to_err", req_err, 2'b01);
    checkOutput("to_rdata", rdata, 8'hFF);
    checkOutput("to_m_start", m_start, 1'b0);
    checkOutput("to_latency_window",
                16'((cycle - acc >= Timeout) && (cycle - acc <= Timeout + 4)), 16'd1);
    step();
    m_end   = 1'b1;
    m_rdata = 8'h12;
    step();
    m_end = 1'b0;
    checkOutput("late_end_done", req_done, 2'b00);
    checkOutput("late_end_err", req_err, 2'b00);
    checkOutput("late_end_rdata", rdata, 8'hFF);
    step();
    checkOutput("late_end_done2", req_done, 2'b00);
`else
    acc = 0;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
